// File: rtl/rfft_pkg.sv
// Shared definitions for the 8-point real FFT controller: default geometry,
// FSM state encoding and the constant mux selects driven while a run is active.
package rfft_pkg;

  localparam int RFFT_ADDR_BIT   = 3;
  localparam int RFFT_MEM_HEIGHT = 8;
  localparam int RFFT_ENG_LAT    = 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Datapath mux selects that do not change between stages.
  localparam logic       M11_SEL = 1'b0;
  localparam logic [1:0] M12_SEL = 2'd1;
  localparam logic [1:0] M13_SEL = 2'd2;
  localparam logic       M14_SEL = 1'b1;

endpackage

// File: rtl/rfft_wr_delay.sv
// Fixed-depth shift register that replays {wr_en, addr_write} DEPTH cycles
// after the read issue, matching the butterfly engine latency.
module rfft_wr_delay #(
  parameter int W     = 13,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [DEPTH-1:0][W-1:0] pipe;

  // Shift one slot per cycle; reset drops every in-flight write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe <= '0;
    end else begin
      pipe[0] <= d;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign q = pipe[DEPTH-1];

endmodule

// File: rtl/rfft_ctrl.sv
// Two-stage, two-butterfly-per-stage controller for a radix-4 real FFT engine.
// Sequences in-place memory reads, delayed writes, twiddle index and mux selects.
module rfft_ctrl
  import rfft_pkg::*;
#(
  parameter int ADDR_BIT   = RFFT_ADDR_BIT,
  parameter int MEM_HEIGHT = RFFT_MEM_HEIGHT,
  parameter int ENG_LAT    = RFFT_ENG_LAT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_rd,
  output logic                  busy,
  output logic                  done,
  output logic                  m0,
  output logic                  m11,
  output logic [1:0]            m12,
  output logic [1:0]            m13,
  output logic                  m14,
  output logic                  m21,
  output logic                  m22,
  output logic                  m23,
  output logic                  m24,
  output logic                  bypass_en,
  output logic [ADDR_BIT-1:0]   tw_idx,
  output logic [ADDR_BIT*4-1:0] addr_read,
  output logic [ADDR_BIT*4-1:0] addr_write,
  output logic                  wr_en
);

  localparam int AW4 = ADDR_BIT * 4;
  localparam int CW  = (ENG_LAT > 1) ? $clog2(ENG_LAT) : 1;
  // Butterflies per stage: each consumes 4 words.
  localparam logic [ADDR_BIT-1:0] BFLY_LAST  = ADDR_BIT'(MEM_HEIGHT / 4 - 1);
  localparam logic [CW-1:0]       DRAIN_LAST = CW'(ENG_LAT - 1);

  state_t              state, nxt_state;
  logic                stage, nxt_stage;
  logic [ADDR_BIT-1:0] bfly, nxt_bfly;
  logic [CW-1:0]       cnt, nxt_cnt;
  logic                issue;
  logic                nxt_act;
  logic [AW4-1:0]      nxt_addr;
  logic [ADDR_BIT-1:0] nxt_tw;
  logic [AW4:0]        dly_q;

  // Stage 0 consumes an upstream group, so it can only issue when one is present.
  assign issue = (state == S_ISSUE) && (stage || in_valid);
  assign in_rd = issue && !stage;

  // Next-state and counter update.
  always_comb begin
    nxt_state = state;
    nxt_stage = stage;
    nxt_bfly  = bfly;
    nxt_cnt   = cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          nxt_state = S_ISSUE;
          nxt_stage = 1'b0;
          nxt_bfly  = '0;
        end
      end
      S_ISSUE: begin
        if (issue) begin
          if (bfly == BFLY_LAST) begin
            nxt_state = S_DRAIN;
            nxt_cnt   = '0;
          end else begin
            nxt_bfly = bfly + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        // Hold off the next stage until the last write of this one has landed.
        if (cnt == DRAIN_LAST) begin
          nxt_cnt  = '0;
          nxt_bfly = '0;
          if (!stage) begin
            nxt_state = S_ISSUE;
            nxt_stage = 1'b1;
          end else begin
            nxt_state = S_DONE;
          end
        end else begin
          nxt_cnt = cnt + 1'b1;
        end
      end
      S_DONE: begin
        nxt_state = S_IDLE;
        nxt_stage = 1'b0;
        nxt_bfly  = '0;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Read addresses and twiddle index for the upcoming cycle; a0 sits in the MSBs.
  always_comb begin
    nxt_act  = (nxt_state == S_ISSUE) || (nxt_state == S_DRAIN);
    nxt_addr = '0;
    nxt_tw   = '0;
    if (nxt_act) begin
      for (int k = 0; k < 4; k++) begin
        if (!nxt_stage)
          nxt_addr[AW4-1-k*ADDR_BIT -: ADDR_BIT] = nxt_bfly + ADDR_BIT'(2 * k);
        else
          nxt_addr[AW4-1-k*ADDR_BIT -: ADDR_BIT] = (nxt_bfly << 2) + ADDR_BIT'(k);
      end
      if (nxt_stage) nxt_tw = nxt_bfly << 1;
    end
  end

  // State registers plus registered control outputs aligned with addr_read.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      stage     <= 1'b0;
      bfly      <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      addr_read <= '0;
      tw_idx    <= '0;
      bypass_en <= 1'b1;
      m0        <= 1'b0;
      m11       <= 1'b0;
      m12       <= 2'd0;
      m13       <= 2'd0;
      m14       <= 1'b0;
      m21       <= 1'b0;
      m22       <= 1'b0;
      m23       <= 1'b0;
      m24       <= 1'b0;
    end else begin
      state     <= nxt_state;
      stage     <= nxt_stage;
      bfly      <= nxt_bfly;
      cnt       <= nxt_cnt;
      busy      <= (nxt_state != S_IDLE);
      done      <= (nxt_state == S_DONE);
      addr_read <= nxt_addr;
      tw_idx    <= nxt_tw;
      bypass_en <= (nxt_tw == '0);
      m0        <= nxt_act && nxt_stage;
      m11       <= (nxt_state != S_IDLE) ? M11_SEL : 1'b0;
      m12       <= (nxt_state != S_IDLE) ? M12_SEL : 2'd0;
      m13       <= (nxt_state != S_IDLE) ? M13_SEL : 2'd0;
      m14       <= (nxt_state != S_IDLE) ? M14_SEL : 1'b0;
      m21       <= nxt_act && nxt_stage;
      m22       <= nxt_act && nxt_stage;
      m23       <= nxt_act && nxt_stage;
      m24       <= nxt_act && nxt_stage;
    end
  end

  rfft_wr_delay #(
    .W     (AW4 + 1),
    .DEPTH (ENG_LAT)
  ) u_wr_delay (
    .clk (clk),
    .rst (rst),
    .d   ({issue, addr_read}),
    .q   (dly_q)
  );

  assign wr_en      = dly_q[AW4];
  assign addr_write = dly_q[AW4-1:0];

endmodule

// File: tb/tb_rfft_ctrl.sv
// Directed bench for rfft_ctrl: nominal vector table plus stall, start-ignore
// and mid-run reset sequences.
module tb_rfft_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic        in_rd, busy, done, m0, m11, m14, m21, m22, m23, m24;
  logic [1:0]  m12, m13;
  logic        bypass_en, wr_en;
  logic [2:0]  tw_idx;
  logic [11:0] addr_read, addr_write;

  int checks = 0;
  int errors = 0;

  rfft_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_valid   (in_valid),
    .in_rd      (in_rd),
    .busy       (busy),
    .done       (done),
    .m0         (m0),
    .m11        (m11),
    .m12        (m12),
    .m13        (m13),
    .m14        (m14),
    .m21        (m21),
    .m22        (m22),
    .m23        (m23),
    .m24        (m24),
    .bypass_en  (bypass_en),
    .tw_idx     (tw_idx),
    .addr_read  (addr_read),
    .addr_write (addr_write),
    .wr_en      (wr_en)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] ar;
    logic        ird;
    logic        wr;
    logic [11:0] aw;
    logic        bsy;
    logic        dn;
    logic [2:0]  tw;
    logic        byp;
    logic        mm0;
    logic        mm2;
  } vec_t;

  vec_t vecs[9];

  function automatic logic [11:0] pk(int a0, int a1, int a2, int a3);
    return {3'(a0), 3'(a1), 3'(a2), 3'(a3)};
  endfunction

  function automatic vec_t mk(logic [11:0] ar, logic ird, logic wr, logic [11:0] aw,
                              logic bsy, logic dn, logic [2:0] tw, logic byp,
                              logic mm0, logic mm2);
    vec_t v;
    v.ar = ar; v.ird = ird; v.wr = wr; v.aw = aw; v.bsy = bsy; v.dn = dn;
    v.tw = tw; v.byp = byp; v.mm0 = mm0; v.mm2 = mm2;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_vec(int c, vec_t v);
    string p;
    p = $sformatf("c%0d", c);
    chk({p, " addr_read"}, 32'(addr_read), 32'(v.ar));
    chk({p, " in_rd"}, 32'(in_rd), 32'(v.ird));
    chk({p, " wr_en"}, 32'(wr_en), 32'(v.wr));
    if (v.wr) chk({p, " addr_write"}, 32'(addr_write), 32'(v.aw));
    chk({p, " busy"}, 32'(busy), 32'(v.bsy));
    chk({p, " done"}, 32'(done), 32'(v.dn));
    chk({p, " tw_idx"}, 32'(tw_idx), 32'(v.tw));
    chk({p, " bypass_en"}, 32'(bypass_en), 32'(v.byp));
    chk({p, " m0"}, 32'(m0), 32'(v.mm0));
    chk({p, " m2x"}, 32'({m21, m22, m23, m24}), v.mm2 ? 32'hF : 32'h0);
    if (v.bsy) chk({p, " m1x"}, 32'({m11, m12, m13, m14}), 32'b0_01_10_1);
  endtask

  // Called at a negedge with the DUT idle; start is sampled at the next edge (edge 0).
  task automatic run_table(string tag);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 9; c++) begin
      @(negedge clk);
      start = 1'b0;
      #1;
      check_vec(c, vecs[c-1]);
    end
    @(negedge clk); #1;
    chk({tag, " idle busy"}, 32'(busy), 32'd0);
    chk({tag, " idle done"}, 32'(done), 32'd0);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("wait_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int done_cyc, done_cnt, wr_cyc;
    vecs[0] = mk(pk(0,2,4,6), 1, 0, 12'd0,      1, 0, 0, 1, 0, 0);
    vecs[1] = mk(pk(1,3,5,7), 1, 0, 12'd0,      1, 0, 0, 1, 0, 0);
    vecs[2] = mk(pk(1,3,5,7), 0, 1, pk(0,2,4,6), 1, 0, 0, 1, 0, 0);
    vecs[3] = mk(pk(1,3,5,7), 0, 1, pk(1,3,5,7), 1, 0, 0, 1, 0, 0);
    vecs[4] = mk(pk(0,1,2,3), 0, 0, 12'd0,      1, 0, 0, 1, 1, 1);
    vecs[5] = mk(pk(4,5,6,7), 0, 0, 12'd0,      1, 0, 2, 0, 1, 1);
    vecs[6] = mk(pk(4,5,6,7), 0, 1, pk(0,1,2,3), 1, 0, 2, 0, 1, 1);
    vecs[7] = mk(pk(4,5,6,7), 0, 1, pk(4,5,6,7), 1, 0, 2, 0, 1, 1);
    vecs[8] = mk(12'd0,       0, 0, 12'd0,      1, 1, 0, 1, 0, 0);

    rst = 1'b1; start = 1'b0; in_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst done", 32'(done), 32'd0);
    chk("rst in_rd", 32'(in_rd), 32'd0);
    chk("rst wr_en", 32'(wr_en), 32'd0);
    chk("rst addr", 32'({addr_read, addr_write}), 32'd0);
    chk("rst tw_idx", 32'(tw_idx), 32'd0);
    chk("rst bypass_en", 32'(bypass_en), 32'd1);
    chk("rst mux", 32'({m0, m11, m12, m13, m14, m21, m22, m23, m24}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Nominal run.
    run_table("nominal");

    // Stall: no upstream group for the first three issue cycles.
    @(negedge clk);
    in_valid = 1'b0; start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); start = 1'b0; #1;
      chk($sformatf("stall c%0d in_rd", c), 32'(in_rd), 32'd0);
      chk($sformatf("stall c%0d addr", c), 32'(addr_read), 32'(pk(0,2,4,6)));
      chk($sformatf("stall c%0d busy", c), 32'(busy), 32'd1);
      chk($sformatf("stall c%0d wr_en", c), 32'(wr_en), 32'd0);
    end
    @(negedge clk); in_valid = 1'b1; #1;
    chk("stall c4 in_rd", 32'(in_rd), 32'd1);
    chk("stall c4 addr", 32'(addr_read), 32'(pk(0,2,4,6)));
    done_cyc = -1; wr_cyc = -1;
    for (int c = 5; c <= 25; c++) begin
      @(negedge clk); #1;
      if (wr_en && wr_cyc < 0) begin
        wr_cyc = c;
        chk("stall first addr_write", 32'(addr_write), 32'(pk(0,2,4,6)));
      end
      if (done) begin done_cyc = c; break; end
    end
    chk("stall first wr cycle", 32'(wr_cyc), 32'd6);
    chk("stall done cycle", 32'(done_cyc), 32'd12);
    wait_idle();

    // start pulsed mid-run must be ignored.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    done_cnt = 0; done_cyc = -1;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      start = (c == 4);
      #1;
      if (done) begin done_cnt++; if (done_cyc < 0) done_cyc = c; end
    end
    start = 1'b0;
    chk("restart done count", 32'(done_cnt), 32'd1);
    chk("restart done cycle", 32'(done_cyc), 32'd9);
    chk("restart idle", 32'(busy), 32'd0);

    // Reset inside the first drain, then a full nominal run.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk); start = 1'b0;
    end
    #1;
    chk("pre-rst wr_en", 32'(wr_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid-rst busy", 32'(busy), 32'd0);
    chk("mid-rst wr_en", 32'(wr_en), 32'd0);
    chk("mid-rst addr", 32'(addr_read), 32'd0);
    chk("mid-rst bypass_en", 32'(bypass_en), 32'd1);
    @(negedge clk); #1;
    chk("mid-rst held wr_en", 32'(wr_en), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_table("post-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule

// File: doc/rfft_ctrl.md
RFFT_CTRL -- requirements
Module: rfft_ctrl

Interface
REQ-001 SHALL have parameter ADDR_BIT, default 3, memory address width.
REQ-002 SHALL have parameter MEM_HEIGHT, default 8, number of memory words; fixed at 2 butterflies per stage, 2 stages.
REQ-003 SHALL have parameter ENG_LAT, default 2, rfft_4pt read-to-write latency in cycles.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1, posedge clock; rst input 1, asynchronous active-high reset.
REQ-005 Ports: start input 1 run request; in_valid input 1 upstream 4-sample group present; in_rd output 1 group consumed this cycle.
REQ-006 Ports: busy output 1; done output 1 one-cycle completion pulse.
REQ-007 Ports: m0 output 1 input-source select; m11, m14 output 1; m12, m13 output 2; m21..m24 output 1 each.
REQ-008 Ports: bypass_en output 1; tw_idx output ADDR_BIT twiddle ROM index.
REQ-009 Ports: addr_read output ADDR_BIT*4; addr_write output ADDR_BIT*4; wr_en output 1.
REQ-010 Address packing SHALL be {a0,a1,a2,a3}, with a0 in the MSBs.

Function
REQ-011 SHALL implement FSM IDLE -> ISSUE -> DRAIN -> (ISSUE of next stage | DONE) -> IDLE.
REQ-012 In IDLE, start=1 SHALL load stage=0, bfly=0 and enter ISSUE on the next edge; start SHALL be ignored in all other states.
REQ-013 ISSUE cycle: the butterfly issues when stage!=0 or in_valid=1; in stage 0 with in_valid=0 the FSM SHALL stall with all counters held.
REQ-014 in_rd SHALL be 1 exactly on stage-0 issue cycles.
REQ-015 Read addresses: stage 0 a_k = bfly + 2k (b0: 0,2,4,6; b1: 1,3,5,7); stage 1 a_k = 4*bfly + k (b0: 0-3; b1: 4-7).
REQ-016 addr_write and wr_en SHALL equal addr_read and the issue strobe delayed exactly ENG_LAT cycles; writes are in place.
REQ-017 After the bfly=1 issue, the FSM SHALL enter DRAIN for exactly ENG_LAT cycles, so no stage-1 read precedes the last stage-0 write.
REQ-018 After DRAIN, stage 0 SHALL go to ISSUE with stage=1, bfly=0; stage 1 SHALL go to DONE.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 busy SHALL be 1 in ISSUE, DRAIN and DONE, and 0 in IDLE.
REQ-021 m0 SHALL be 0 in stage 0 (external in0..in3) and 1 in stage 1 (memory).
REQ-022 m11=0, m12=1, m13=2 and m14=1 SHALL be constant while busy; m21..m24 SHALL be 1 in stage 1 (output reorder) and 0 otherwise.
REQ-023 tw_idx SHALL be 0 in stage 0 and bfly<<1 in stage 1, with arithmetic mod 2^ADDR_BIT.
REQ-024 bypass_en SHALL be 1 whenever tw_idx==0.
REQ-025 Control outputs SHALL be registered and valid in the same cycle as the corresponding addr_read.
REQ-026 Nominal run with in_valid held 1 and start sampled at edge 0: issues at cycles 1,2 and 5,6; writes at 3,4 and 7,8; done at cycle 9.

Reset
REQ-027 rst SHALL force IDLE immediately, with stage=0, bfly=0 and the delay line cleared.
REQ-028 On reset: busy=0, done=0, in_rd=0, wr_en=0, addresses=0, tw_idx=0, m*=0, bypass_en=1.
REQ-029 Reset mid-run SHALL drop all pending writes, so wr_en=0 from the reset edge.

Structure
REQ-030 Package rfft_pkg SHALL hold the FSM state encoding, ADDR_BIT/MEM_HEIGHT/ENG_LAT defaults and the stage mux-select constants.
REQ-031 Sub-module rfft_wr_delay SHALL be a parameterised ENG_LAT-deep shift register carrying {wr_en, addr_write}.

Verification
REQ-032 Nominal: start=1 for one cycle with in_valid=1 -> addr_read=000_010_100_110, then 001_011_101_111, 000_001_010_011, 100_101_110_111; done at cycle 9.
REQ-033 Stall: in_valid=0 for 3 cycles at the first issue -> in_rd=0, addresses held, done delayed by 3 cycles.
REQ-034 Write timing: each wr_en pulse appears exactly 2 cycles after its issue, with addr_write equal to the addr_read of that issue.
REQ-035 start pulsed at cycle 4 of a run -> ignored; exactly one done pulse at cycle 9.
REQ-036 rst at cycle 4 (inside the first DRAIN) -> same cycle busy=0 and wr_en=0; a later start gives the full nominal sequence.
REQ-037 Stage 1, bfly=1 -> tw_idx=2, bypass_en=0, m0=1, m21..m24=1.
